rgb_cmd_sequencer: RTL and testbench

Command sequencer between the UART receiver and the RGB PWM stage. It parses ASCII frames arriving byte-by-byte from the UART RX path and updates the three 8-bit duty registers that drive the PWM channels. For every completed or rejected frame it returns a one-byte acknowledge through the UART TX handshake. An idle timeout discards partial frames.

---
 rtl/rgb_cmd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_rgb_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_cmd_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rgb_cmd_sequencer
//
// Parses ASCII colour commands arriving byte-by-byte from the UART receiver
// and updates the three 8-bit duty registers feeding the RGB PWM stage.
//
// Frame format:  <chan> <hex hi> <hex lo> CR
//   chan   : 'R' red, 'G' green, 'B' blue, 'W' all three (uppercase only)
//   hex    : '0'-'9', 'A'-'F', 'a'-'f'
//   LF     : ignored everywhere (no state change, does not restart the
//            idle timer)
//
// Every completed frame answers 'K' (0x4B); every rejected frame answers
// '?' (0x3F) and pulses cmd_err. A frame left idle for TIMEOUT_CYCLES-1
// clocks after its last accepted byte is abandoned silently with a timeout
// pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   rx_valid  in   single-cycle strobe, rx_data holds a received byte
//   rx_data   in   [7:0] received byte
//   tx_ready  in   UART TX accepts a byte this cycle
//   tx_valid  out  acknowledge byte offered on tx_data
//   tx_data   out  [7:0] acknowledge byte ('K' or '?')
//   duty_r    out  [7:0] red duty register
//   duty_g    out  [7:0] green duty register
//   duty_b    out  [7:0] blue duty register
//   cmd_err   out  one-cycle pulse when a frame is rejected
//   timeout   out  one-cycle pulse when a partial frame is abandoned
//
// TX handshake: tx_valid rises on entry to ACK and tx_data stays constant
// while tx_valid is high. The byte transfers at the first rising edge with
// tx_valid && tx_ready; tx_valid drops after that edge and the parser is back
// in IDLE on the same edge. Received bytes seen while in ACK are discarded.
// -----------------------------------------------------------------------------
module rgb_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic       cmd_err,
    output logic       timeout
);

    // Counter only has to reach TIMEOUT_CYCLES-2; the expiry decision is
    // taken on the clock that would move it to TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_R   = 8'h52;
    localparam logic [7:0] CHR_G   = 8'h47;
    localparam logic [7:0] CHR_B   = 8'h42;
    localparam logic [7:0] CHR_W   = 8'h57;
    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_NAK = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_TERM = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2,
        CH_W = 2'd3
    } chan_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    chan_t            chan;
    logic [3:0]       hi_nib;
    logic [3:0]       lo_nib;
    logic [CNT_W-1:0] idle_cnt;

    // ------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------
    logic       rx_lf;
    logic       rx_byte;      // a received byte that the parser must act on
    logic       chan_ok;
    chan_t      chan_dec;
    logic       hex_ok;
    logic [3:0] hex_nib;

    assign rx_lf   = rx_valid && (rx_data == CHR_LF);
    assign rx_byte = rx_valid && !rx_lf;

    always_comb begin
        chan_ok  = 1'b1;
        chan_dec = CH_R;
        unique case (rx_data)
            CHR_R:   chan_dec = CH_R;
            CHR_G:   chan_dec = CH_G;
            CHR_B:   chan_dec = CH_B;
            CHR_W:   chan_dec = CH_W;
            default: chan_ok  = 1'b0;
        endcase
    end

    always_comb begin
        hex_ok  = 1'b1;
        hex_nib = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_nib = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            hex_nib = 4'(rx_data - 8'h37);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            hex_nib = 4'(rx_data - 8'h57);
        end else begin
            hex_ok  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    logic       in_frame;
    logic       cnt_last;
    logic       reject;
    logic       ld_chan;
    logic       ld_hi;
    logic       ld_lo;
    logic       wr_duty;
    logic       ack_load;
    logic [7:0] ack_byte;
    logic       err_set;
    logic       to_set;
    logic       cnt_clr;
    logic       cnt_inc;

    assign in_frame = (state == ST_HI) || (state == ST_LO) || (state == ST_TERM);
    assign cnt_last = (idle_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        reject    = 1'b0;
        ld_chan   = 1'b0;
        ld_hi     = 1'b0;
        ld_lo     = 1'b0;
        wr_duty   = 1'b0;
        ack_load  = 1'b0;
        ack_byte  = 8'h00;
        err_set   = 1'b0;
        to_set    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (rx_byte) begin
                    if (chan_ok) begin
                        ld_chan   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = ST_HI;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_HI: begin
                if (rx_byte) begin
                    if (hex_ok) begin
                        ld_hi     = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = ST_LO;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_LO: begin
                if (rx_byte) begin
                    if (hex_ok) begin
                        ld_lo     = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = ST_TERM;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_TERM: begin
                if (rx_byte) begin
                    if (rx_data == CHR_CR) begin
                        wr_duty   = 1'b1;
                        ack_load  = 1'b1;
                        ack_byte  = ACK_OK;
                        state_nxt = ST_ACK;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                // rx bytes are intentionally ignored here
                if (tx_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Idle timer: any clock inside a frame without an acted-on byte
        // (including LF-only clocks) ages the frame. An arriving byte on the
        // expiry clock takes priority because this path needs !rx_byte.
        if (in_frame && !rx_byte) begin
            if (cnt_last) begin
                to_set    = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                cnt_inc = 1'b1;
            end
        end

        if (reject) begin
            ack_load  = 1'b1;
            ack_byte  = ACK_NAK;
            err_set   = 1'b1;
            state_nxt = ST_ACK;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan     <= CH_R;
            hi_nib   <= 4'h0;
            lo_nib   <= 4'h0;
            idle_cnt <= '0;
            tx_data  <= 8'h00;
            cmd_err  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            cmd_err <= err_set;
            timeout <= to_set;
            if (ld_chan) begin
                chan <= chan_dec;
            end
            if (ld_hi) begin
                hi_nib <= hex_nib;
            end
            if (ld_lo) begin
                lo_nib <= hex_nib;
            end
            if (cnt_clr) begin
                idle_cnt <= '0;
            end else if (cnt_inc) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
            if (ack_load) begin
                tx_data <= ack_byte;
            end
        end
    end

    // Duty registers change only on a CR that completes a well-formed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_r <= 8'h00;
            duty_g <= 8'h00;
            duty_b <= 8'h00;
        end else if (wr_duty) begin
            if (chan == CH_R || chan == CH_W) begin
                duty_r <= {hi_nib, lo_nib};
            end
            if (chan == CH_G || chan == CH_W) begin
                duty_g <= {hi_nib, lo_nib};
            end
            if (chan == CH_B || chan == CH_W) begin
                duty_b <= {hi_nib, lo_nib};
            end
        end
    end

    assign tx_valid = (state == ST_ACK);

endmodule

// File: tb/tb_rgb_cmd_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rgb_cmd_sequencer
//
// Directed scenarios plus randomized frames for rgb_cmd_sequencer. A monitor
// records every transferred ack byte and every cmd_err/timeout pulse; each
// scenario compares those against the values it expects.
// -----------------------------------------------------------------------------
module tb_rgb_cmd_sequencer;

  localparam int TO = 16;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] K  = 8'h4B;
  localparam logic [7:0] Q  = 8'h3F;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [7:0] duty_r, duty_g, duty_b;
  logic       cmd_err, timeout;

  always #5 clk = ~clk;

  rgb_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .cmd_err(cmd_err), .timeout(timeout)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int exp_err = 0, err_seen = 0;
  int exp_to = 0, to_seen = 0;
  logic [7:0] exp_r, exp_g, exp_b;
  logic [7:0] frame_q[$];

  // Inputs change at posedge+1, so at negedge they are stable for the edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) obs_q.push_back(tx_data);
    if (cmd_err) err_seen++;
    if (timeout) to_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'(($urandom_range(0, 255)));
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic bit is_chan(input logic [7:0] c);
    return c == "R" || c == "G" || c == "B" || c == "W";
  endfunction

  // A frame (LFs removed) is accepted only as chan, hex, hex, CR.
  task automatic model_frame();
    logic [7:0] s[$];
    int v;
    foreach (frame_q[i]) if (frame_q[i] != LF) s.push_back(frame_q[i]);
    if (s.size() == 4 && is_chan(s[0]) && is_hex(s[1]) && is_hex(s[2]) && s[3] == CR) begin
      v = hex_val(s[1]) * 16 + hex_val(s[2]);
      if (s[0] == "R" || s[0] == "W") exp_r = 8'(v);
      if (s[0] == "G" || s[0] == "W") exp_g = 8'(v);
      if (s[0] == "B" || s[0] == "W") exp_b = 8'(v);
      exp_q.push_back(K);
    end else begin
      exp_q.push_back(Q);
      exp_err++;
    end
  endtask

  function automatic bit slot_ok(input int p, input logic [7:0] b);
    if (p == 0) return is_chan(b);
    if (p == 3) return b == CR;
    return is_hex(b);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    n_vec++; if ({duty_r, duty_g, duty_b} !== 24'h0) begin n_err++; $display("FAIL reset_duty got=%h want=000000", {duty_r, duty_g, duty_b}); end
    n_vec++; if ({cmd_err, timeout} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got=%b want=00", {cmd_err, timeout}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    send_byte("R"); send_byte("8"); send_byte("0");
    n_vec++; if (duty_r !== 8'h00) begin n_err++; $display("FAIL basic_pre_cr got=%h want=00", duty_r); end
    send_byte(CR);
    exp_q.push_back(K);
    n_vec++; if ({duty_r, duty_g, duty_b} !== 24'h800000) begin n_err++; $display("FAIL basic_duty got=%h want=800000", {duty_r, duty_g, duty_b}); end
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== K) begin n_err++; $display("FAIL basic_ack got=%b/%h want=1/4b", tx_valid, tx_data); end
    idle(1);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL basic_ack_len got=%b want=0", tx_valid); end
    idle(2);
  endtask

  task automatic test_white_lf();
    send_byte("W"); send_byte("f"); send_byte("F"); send_byte(LF); send_byte(CR);
    exp_q.push_back(K);
    n_vec++; if ({duty_r, duty_g, duty_b} !== 24'hFFFFFF) begin n_err++; $display("FAIL white_duty got=%h want=ffffff", {duty_r, duty_g, duty_b}); end
    idle(3);
  endtask

  task automatic test_reject();
    send_byte("G"); send_byte("1"); send_byte("Z");
    exp_q.push_back(Q); exp_err++;
    n_vec++; if (cmd_err !== 1'b1) begin n_err++; $display("FAIL reject_err got=%b want=1", cmd_err); end
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== Q) begin n_err++; $display("FAIL reject_ack got=%b/%h want=1/3f", tx_valid, tx_data); end
    n_vec++; if (duty_g !== 8'hFF) begin n_err++; $display("FAIL reject_duty got=%h want=ff", duty_g); end
    idle(1);
    n_vec++; if (cmd_err !== 1'b0 || tx_valid !== 1'b0) begin n_err++; $display("FAIL reject_after got=%b/%b want=0/0", cmd_err, tx_valid); end
    send_byte("G"); send_byte("1"); send_byte("0"); send_byte(CR);
    exp_q.push_back(K);
    n_vec++; if (duty_g !== 8'h10) begin n_err++; $display("FAIL reject_retry got=%h want=10", duty_g); end
    idle(3);
  endtask

  task automatic test_stall();
    logic [7:0] sb[4];
    sb[0] = "B"; sb[1] = "0"; sb[2] = "0"; sb[3] = CR;
    tx_ready = 1'b0;
    send_byte("B"); send_byte("3"); send_byte("7"); send_byte(CR);
    exp_q.push_back(K);
    for (int i = 0; i < 20; i++) begin
      if (i < 4) send_byte(sb[i]); else idle(1);
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== K || duty_b !== 8'h37) begin
        n_err++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h want=1/4b/37", i, tx_valid, tx_data, duty_b);
      end
    end
    tx_ready = 1'b1;
    idle(1);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got=%b want=0", tx_valid); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    send_byte("R"); send_byte("1"); send_byte("1"); send_byte(CR);
    exp_q.push_back(K);
    send_byte("X");  // lands on the transfer edge and must be dropped
    send_byte("R"); send_byte("2"); send_byte("2"); send_byte(CR);
    exp_q.push_back(K);
    n_vec++; if (duty_r !== 8'h22) begin n_err++; $display("FAIL b2b_duty got=%h want=22", duty_r); end
    idle(3);
  endtask

  task automatic test_timeout();
    send_byte("B"); send_byte("4");
    for (int k = 1; k <= TO - 1; k++) begin
      idle(1);
      n_vec++;
      if (timeout !== (k == TO - 1) || tx_valid !== 1'b0) begin
        n_err++; $display("FAIL timeout_pulse clk=%0d got=%b/%b want=%b/0", k, timeout, tx_valid, (k == TO - 1));
      end
    end
    exp_to++;
    n_vec++; if (duty_b !== 8'h37) begin n_err++; $display("FAIL timeout_duty got=%h want=37", duty_b); end
    send_byte("B"); send_byte("4"); send_byte("2"); send_byte(CR);
    exp_q.push_back(K);
    n_vec++; if (duty_b !== 8'h42) begin n_err++; $display("FAIL timeout_next got=%h want=42", duty_b); end
    idle(2);
    // byte on the expiry edge wins
    send_byte("B"); send_byte("4");
    idle(TO - 2);
    send_byte("7"); send_byte(CR);
    exp_q.push_back(K);
    n_vec++; if (duty_b !== 8'h47) begin n_err++; $display("FAIL timeout_race got=%h want=47", duty_b); end
    idle(2);
    // LF does not restart the idle timer
    send_byte("G"); send_byte("3");
    idle(5); send_byte(LF); idle(TO - 8);
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_lf_early got=%b want=0", timeout); end
    idle(1);
    exp_to++;
    n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_lf got=%b want=1", timeout); end
    idle(2);
  endtask

  task automatic test_async_reset();
    send_byte("R"); send_byte("1");
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({duty_r, duty_g, duty_b} !== 24'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || cmd_err !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL areset_lo got=%h/%b/%h want=000000/0/00", {duty_r, duty_g, duty_b}, tx_valid, tx_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    idle(1);
    tx_ready = 1'b0;
    send_byte("G"); send_byte("5"); send_byte("5"); send_byte(CR);
    n_vec++; if (tx_valid !== 1'b1 || duty_g !== 8'h55) begin n_err++; $display("FAIL areset_setup got=%b/%h want=1/55", tx_valid, duty_g); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({duty_r, duty_g, duty_b} !== 24'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_err++; $display("FAIL areset_ack got=%h/%b/%h want=000000/0/00", {duty_r, duty_g, duty_b}, tx_valid, tx_data);
    end
    @(posedge clk); #1; rst = 1'b0; tx_ready = 1'b1;
    idle(1);
    send_byte("W"); send_byte("3"); send_byte("c"); send_byte(CR);
    exp_q.push_back(K);
    exp_r = 8'h3C; exp_g = 8'h3C; exp_b = 8'h3C;
    n_vec++; if ({duty_r, duty_g, duty_b} !== 24'h3C3C3C) begin n_err++; $display("FAIL areset_after got=%h want=3c3c3c", {duty_r, duty_g, duty_b}); end
    idle(3);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int f = 0; f < 60; f++) begin
      frame_q.delete();
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 4) == 0) frame_q.push_back(LF);
        if ($urandom_range(0, 5) == 0) begin
          do b = 8'($urandom_range(0, 255)); while (slot_ok(p, b) || b == LF);
          frame_q.push_back(b);
          break;
        end
        case (p)
          0: case ($urandom_range(0, 3)) 0: b = "R"; 1: b = "G"; 2: b = "B"; default: b = "W"; endcase
          3: b = CR;
          default: begin
            b = 8'($urandom_range(0, 21));
            b = (b < 10) ? 8'(b + 8'h30) : (b < 16) ? 8'(b + 8'h37) : 8'(b + 8'h51);
          end
        endcase
        frame_q.push_back(b);
      end
      model_frame();
      foreach (frame_q[i]) begin
        send_byte(frame_q[i]);
        if (i + 1 < frame_q.size()) idle($urandom_range(0, 3));
      end
      idle(1 + $urandom_range(0, 2));
      n_vec++;
      if ({duty_r, duty_g, duty_b} !== {exp_r, exp_g, exp_b}) begin
        n_err++; $display("FAIL random_duty frame=%0d got=%h want=%h", f, {duty_r, duty_g, duty_b}, {exp_r, exp_g, exp_b});
      end
    end
    idle(2);
  endtask

  // ---------------- sequencing and scoreboard ----------------
  initial begin
    exp_r = 8'h00; exp_g = 8'h00; exp_b = 8'h00;
    for (int t = 0; t < 9; t++) begin
      case (t)
        0: test_reset();
        1: test_basic();
        2: test_white_lf();
        3: test_reject();
        4: test_stall();
        5: test_back_to_back();
        6: test_timeout();
        7: test_async_reset();
        default: test_random();
      endcase
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL test%0d_tx_beats got=%0d want=%0d", t, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        if (i < obs_q.size()) begin
          n_vec++;
          if (obs_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL test%0d_tx_byte idx=%0d got=%h want=%h", t, i, obs_q[i], exp_q[i]);
          end
        end
      end
      n_vec++; if (err_seen != exp_err) begin n_err++; $display("FAIL test%0d_cmd_err got=%0d want=%0d", t, err_seen, exp_err); end
      n_vec++; if (to_seen != exp_to) begin n_err++; $display("FAIL test%0d_timeouts got=%0d want=%0d", t, to_seen, exp_to); end
      obs_q.delete();
      exp_q.delete();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
